// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: serial-in / parallel-out frame receiver.
// Frame: start bit (0), WIDTH data bits LSB first, optional even-parity bit,
// stop bit (1). A good frame is committed to data_out/data_valid on the edge
// that samples its stop bit. data_out is held by a valid/ready handshake.
// Optional feature: define PARITY_EN to expect an even-parity bit after the data bits.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_last_bit;
    logic             w_commit;
    logic             w_stop_bad;
    logic             w_handshake;
`ifdef PARITY_EN
    logic             r_parity_err;
    logic             w_par_bad;
`endif

    // The counter reaches WIDTH at most, so it never wraps inside a frame.
    assign w_last_bit  = (r_cnt == CW'(WIDTH - 1));
    assign w_handshake = r_valid && data_ready;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus per-frame outcome strobes (commit / bad stop / bad parity).
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_stop_bad   = 1'b0;
`ifdef PARITY_EN
        w_par_bad    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!serial_in) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_last_bit) begin
`ifdef PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef PARITY_EN
                // All data bits are in r_shift here; even parity means the XOR is 0.
                if ((^r_shift) ^ serial_in) begin
                    w_par_bad    = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = STOP;
                end
`else
                w_state_next = IDLE;
`endif
            end
            STOP: begin
                w_state_next = IDLE;
                if (serial_in) begin
                    w_commit = 1'b1;
                end else begin
                    w_stop_bad = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Bit counter: held at 0 while idle so the first data bit lands at position 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == DATA) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Shift register: each data cycle writes serial_in at the position given by the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (r_state == DATA) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_cnt == CW'(i)) begin
                    r_shift[i] <= serial_in;
                end
            end
        end
    end

    // Output holding register, valid/ready handshake, and one-cycle error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= 1'b0;
            if (w_commit) begin
                // A frame arriving while the previous one is still unconsumed is dropped.
                if (r_valid && !data_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_EN
    // Parity error pulse, registered so it appears the cycle after the parity bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_par_bad;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: directed and randomized frames for sipo_frame_ctrl (WIDTH=4).
// Expectations come from a frame-level model: the consumer's pending word and
// valid flag, updated per clock edge from the handshake and per frame outcome.
module tb_sipo_frame_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         serial_in;
    logic         data_ready;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;
    logic         parity_err;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the consumer should currently see.
    logic         exp_valid;
    logic [W-1:0] exp_data;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chkd(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One idle cycle on the line (serial_in high).
    task automatic idle_cycle(input logic rdy);
        logic hs;
        serial_in  = 1'b1;
        data_ready = rdy;
        hs = exp_valid && rdy;
        @(posedge clk);
        #1;
        if (hs) exp_valid = 1'b0;
        chk1("idle_valid", data_valid, exp_valid);
        chkd("idle_data", data_out, exp_data);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_ferr", frame_err, 1'b0);
        chk1("idle_ovr", overrun, 1'b0);
        chk1("idle_perr", parity_err, 1'b0);
    endtask

    // One complete frame. rdy_data is data_ready during start/data(/parity) bits,
    // rdy_stop is data_ready on the stop-bit edge.
    task automatic send_frame(input logic [W-1:0] d, input logic stop_ok, input logic par_bad,
                              input logic rdy_data, input logic rdy_stop);
        logic hs;
        logic exp_ovr;
        for (int i = 0; i <= W; i++) begin
            serial_in  = (i == 0) ? 1'b0 : d[i-1];
            data_ready = rdy_data;
            hs = exp_valid && rdy_data;
            @(posedge clk);
            #1;
            if (hs) exp_valid = 1'b0;
            chk1("mid_busy", busy, 1'b1);
            chk1("mid_valid", data_valid, exp_valid);
            chkd("mid_data", data_out, exp_data);
            chk1("mid_ferr", frame_err, 1'b0);
            chk1("mid_ovr", overrun, 1'b0);
            chk1("mid_perr", parity_err, 1'b0);
        end
`ifdef PARITY_EN
        serial_in  = (^d) ^ par_bad;
        data_ready = rdy_data;
        hs = exp_valid && rdy_data;
        @(posedge clk);
        #1;
        if (hs) exp_valid = 1'b0;
        chk1("par_perr", parity_err, par_bad);
        chk1("par_busy", busy, !par_bad);
        chk1("par_valid", data_valid, exp_valid);
        chkd("par_data", data_out, exp_data);
        if (par_bad) begin
            $display("frame d=%h parity_bad -> data_out=%h valid=%b", d, data_out, data_valid);
            return;
        end
`else
        if (par_bad) begin
            // No parity bit in this build; the flag has no effect.
        end
`endif
        serial_in  = stop_ok;
        data_ready = rdy_stop;
        hs = exp_valid && rdy_stop;
        exp_ovr = 1'b0;
        @(posedge clk);
        #1;
        if (stop_ok) begin
            if (exp_valid && !hs) begin
                exp_ovr = 1'b1;
            end else begin
                exp_data  = d;
                exp_valid = 1'b1;
            end
        end else if (hs) begin
            exp_valid = 1'b0;
        end
        chk1("stop_valid", data_valid, exp_valid);
        chkd("stop_data", data_out, exp_data);
        chk1("stop_busy", busy, 1'b0);
        chk1("stop_ferr", frame_err, !stop_ok);
        chk1("stop_ovr", overrun, exp_ovr);
        chk1("stop_perr", parity_err, 1'b0);
        $display("frame d=%h stop=%b rdy=%b/%b -> data_out=%h valid=%b ferr=%b ovr=%b",
                 d, stop_ok, rdy_data, rdy_stop, data_out, data_valid, frame_err, overrun);
    endtask

    initial begin
        // Reset for 7 ns; outputs must be cleared while reset is low.
        reset      = 1'b0;
        serial_in  = 1'b1;
        data_ready = 1'b0;
        exp_valid  = 1'b0;
        exp_data   = '0;
        #6;
        chk1("rst_valid", data_valid, 1'b0);
        chkd("rst_data", data_out, '0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ferr", frame_err, 1'b0);
        chk1("rst_ovr", overrun, 1'b0);
        chk1("rst_perr", parity_err, 1'b0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle(1'b0);
        idle_cycle(1'b0);

        // Basic frame 1011, then a second frame dropped as overrun.
        send_frame(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Framing error, then a good frame.
        send_frame(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);

        // Handshake on the same edge as a commit: new frame loaded, no overrun.
        send_frame(4'b1110, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycle(1'b1);

        // Reset pulse during data bit 2 abandons the frame silently.
        send_frame(4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
        serial_in = 1'b0;
        @(posedge clk);
        serial_in = 1'b0;
        @(posedge clk);
        serial_in = 1'b1;
        @(posedge clk);
        #1;
        serial_in = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        exp_valid = 1'b0;
        exp_data  = '0;
        chk1("midrst_valid", data_valid, 1'b0);
        chkd("midrst_data", data_out, '0);
        chk1("midrst_busy", busy, 1'b0);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle(1'b0);
        send_frame(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b1);

`ifdef PARITY_EN
        // Good parity then bad parity.
        send_frame(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b1);
`endif

        // Always-ready consumer with back-to-back frames.
        send_frame(4'b0001, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(4'b1000, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_cycle(1'b1);

        // Randomized frames, gaps and consumer behaviour.
        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] d;
            int gap;
            d   = W'($urandom_range(0, (1 << W) - 1));
            gap = int'($urandom_range(0, 2));
            send_frame(d, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int g = 0; g < gap; g++) begin
                idle_cycle(1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
